ud_cmd_ctrl: RTL and testbench
==============================

# ud_cmd_ctrl

Command-driven sequencer for a WIDTH-bit up/down counter datapath. A requester issues LOAD / CLEAR / count-UP-N / count-DOWN-N commands over a valid/ready handshake. The block steps the counter one count per clock, optionally saturating at the limits, and reports completion and boundary events. It replaces free-running ripple up/down counting wherever software or an upstream FSM needs an exact step count.

## Interface
- WIDTH, 4, width of counter value and of cmd_arg
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  00 LOAD, 01 UP, 10 DOWN, 11 CLEAR
- cmd_arg  in  WIDTH  LOAD value, or step count N for UP/DOWN (ignored for CLEAR)
- cmd_sat  in  1  1 = saturate at 0 / 2^WIDTH-1, 0 = wrap modulo 2^WIDTH; sampled at accept
- abort  in  1  terminate a running UP/DOWN command
- q  out  WIDTH  counter value (registered)
- busy  out  1  UP/DOWN command in progress
- done  out  1  one-cycle completion pulse
- tc  out  1  one-cycle terminal-count pulse (wrap or clamp occurred)

## Operation
- States: IDLE, RUN. Reset enters IDLE.
- cmd_ready = (state == IDLE) and not rst; a command is accepted on a rising edge with cmd_valid & cmd_ready.
- LOAD: q <= cmd_arg at accept edge; done = 1 for the following cycle; stay IDLE.
- CLEAR: q <= 0 at accept edge; done pulse as LOAD; stay IDLE.
- UP/DOWN, N = 0: q unchanged, done pulse next cycle, stay IDLE.
- UP/DOWN, N > 0: at accept edge latch direction, sat mode, remaining <= N; go RUN; q unchanged on the accept edge.
- In RUN, every edge: one step, remaining <= remaining-1. On the edge where remaining == 1: go IDLE, done pulse.
- Step rules:
  - Wrap mode: UP from 2^WIDTH-1 gives 0; DOWN from 0 gives 2^WIDTH-1. tc pulses for the cycle after that edge.
  - Sat mode: UP at 2^WIDTH-1 or DOWN at 0 leaves q unchanged; tc pulses for the cycle after each blocked step.
  - A blocked step still consumes one count, so a command always takes exactly N RUN edges.
- Abort: abort = 1 on an edge while in RUN gives IDLE, no step on that edge, q holds, no done, no tc. Abort in IDLE is ignored. Abort and cmd_valid in the same IDLE cycle: the command is accepted.
- cmd_op/cmd_arg/cmd_sat are don't-care when not accepted. Inputs changing during RUN have no effect except abort.

## Timing
- Reset (asynchronous, immediate): q = 0, state IDLE, busy = 0, done = 0, tc = 0, cmd_ready = 0 while rst is high; cmd_ready = 1 on the first cycle after deassertion.
- Reset mid-RUN: the command is dropped, no done.
- busy = (state == RUN), registered: high from the cycle after accept through the cycle of the last step edge, low in the cycle after it.
- UP/DOWN latency: the accept edge plus N step edges; done and the final q are visible in the same cycle (after edge N).
- LOAD/CLEAR latency: q and done are visible in the cycle after the accept edge.
- Back-to-back: cmd_ready is high in the cycle done is high, so the next command can be accepted on the edge ending the done cycle; no idle bubble is required.
- done and tc are never high for more than one consecutive cycle per event. tc can coincide with done when the final step wraps or clamps.

## Test plan
- Reset then LOAD 4'hA -> q = 10 and done = 1 one cycle after accept; busy stays 0.
- LOAD 3, UP N = 5 (wrap) -> q steps 4,5,6,7,8 on 5 consecutive edges; busy high for 5 cycles; done coincident with q = 8.
- LOAD 14, UP N = 4, sat = 0 -> q = 15,0,1,2; tc pulse in the cycle q = 0. Repeat with sat = 1 -> q = 15,15,15,15; tc pulses 3 times; done after 4 steps.
- LOAD 1, DOWN N = 3, sat = 1 -> q = 0,0,0; tc pulses twice. Then CLEAR -> q = 0, done.
- UP N = 10 from 0, assert abort after 3 steps -> q holds 3; busy drops; no done. cmd_ready returns high and a new LOAD is accepted next edge.
- Assert rst asynchronously mid-RUN (q = 6) -> q = 0 immediately, busy = 0, no done; UP N = 0 afterwards -> done pulse with q unchanged.

Source files
------------

// File: rtl/ud_cmd_ctrl.sv
// Command sequencer for a WIDTH-bit up/down counter (LOAD/CLEAR/UP-N/DOWN-N).
// Latency: LOAD/CLEAR/N=0 report done 1 cycle after accept; UP/DOWN N report done after N step edges.
// Backpressure: o_cmd_ready is high only in IDLE; a running UP/DOWN blocks new commands until it finishes or aborts.
module ud_cmd_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic [1:0]       i_cmd_op,
   input  logic [WIDTH-1:0] i_cmd_arg,
   input  logic             i_cmd_sat,
   input  logic             i_abort,
   output logic [WIDTH-1:0] o_q,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_tc
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_UP    = 2'b01;
   localparam logic [1:0] OP_DOWN  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   state_t           r_state;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_rem;
   logic             r_dir_down;
   logic             r_sat;
   logic             r_done;
   logic             r_tc;

   logic             w_at_limit;
   logic [WIDTH-1:0] w_q_step;
   logic [WIDTH-1:0] w_q_next;

   // Next counter value for one RUN step; a step at the limit either wraps or is blocked
   always_comb begin
      w_at_limit = r_dir_down ? (r_q == '0) : (r_q == '1);
      w_q_step   = r_dir_down ? (r_q - WIDTH'(1)) : (r_q + WIDTH'(1));
      w_q_next   = (w_at_limit && r_sat) ? r_q : w_q_step;
   end

   // Command acceptance, step sequencing, and registered done/tc pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_q        <= '0;
         r_rem      <= '0;
         r_dir_down <= 1'b0;
         r_sat      <= 1'b0;
         r_done     <= 1'b0;
         r_tc       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_tc   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // ready is implied here: IDLE and reset not asserted
               if (i_cmd_valid) begin
                  case (i_cmd_op)
                     OP_LOAD: begin
                        r_q    <= i_cmd_arg;
                        r_done <= 1'b1;
                     end
                     OP_CLEAR: begin
                        r_q    <= '0;
                        r_done <= 1'b1;
                     end
                     default: begin
                        // UP or DOWN; a zero step count completes immediately
                        if (i_cmd_arg == '0) begin
                           r_done <= 1'b1;
                        end else begin
                           r_dir_down <= (i_cmd_op == OP_DOWN);
                           r_sat      <= i_cmd_sat;
                           r_rem      <= i_cmd_arg;
                           r_state    <= S_RUN;
                        end
                     end
                  endcase
               end
            end
            S_RUN: begin
               if (i_abort) begin
                  // abandon the command: no step, no done, no tc
                  r_state <= S_IDLE;
               end else begin
                  r_q   <= w_q_next;
                  r_tc  <= w_at_limit;
                  r_rem <= r_rem - WIDTH'(1);
                  if (r_rem == WIDTH'(1)) begin
                     r_state <= S_IDLE;
                     r_done  <= 1'b1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_cmd_ready = (r_state == S_IDLE) && !rst;
   assign o_busy      = (r_state == S_RUN);
   assign o_q         = r_q;
   assign o_done      = r_done;
   assign o_tc        = r_tc;

endmodule

// File: tb/tb_ud_cmd_ctrl.sv
// Scoreboard bench for ud_cmd_ctrl: stimulus pushes expected {q,busy,done,tc} per active cycle,
// a negedge monitor pops and compares whenever busy, done or tc is high.
// Directed commands with hand-computed expectations.
module tb_ud_cmd_ctrl;

   localparam int WIDTH = 4;

   typedef struct packed {
      logic [WIDTH-1:0] q;
      logic             busy;
      logic             done;
      logic             tc;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             i_cmd_valid = 1'b0;
   logic             o_cmd_ready;
   logic [1:0]       i_cmd_op = 2'b00;
   logic [WIDTH-1:0] i_cmd_arg = '0;
   logic             i_cmd_sat = 1'b0;
   logic             i_abort = 1'b0;
   logic [WIDTH-1:0] o_q;
   logic             o_busy;
   logic             o_done;
   logic             o_tc;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   ud_cmd_ctrl #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_cmd_valid (i_cmd_valid),
      .o_cmd_ready (o_cmd_ready),
      .i_cmd_op    (i_cmd_op),
      .i_cmd_arg   (i_cmd_arg),
      .i_cmd_sat   (i_cmd_sat),
      .i_abort     (i_abort),
      .o_q         (o_q),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_tc        (o_tc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push(input logic [WIDTH-1:0] q, input logic b, input logic d, input logic t);
      exp_t e;
      e.q = q; e.busy = b; e.done = d; e.tc = t;
      sb.push_back(e);
   endtask

   // drive one command in the current cycle; returns just after its accept edge
   task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] arg,
                       input logic sat, input logic ab);
      @(negedge clk);
      i_cmd_valid = 1'b1;
      i_cmd_op    = op;
      i_cmd_arg   = arg;
      i_cmd_sat   = sat;
      i_abort     = ab;
      #1 chk("cmd_ready_at_issue", {31'b0, o_cmd_ready}, 32'd1);
      @(posedge clk);
      #1;
      i_cmd_valid = 1'b0;
      i_abort     = 1'b0;
      i_cmd_arg   = 4'hF;
      i_cmd_op    = 2'b01;
      i_cmd_sat   = ~sat;
   endtask

   // monitor: every cycle with activity must match the next scoreboard entry
   always @(negedge clk) begin
      if (!rst && (o_busy || o_done || o_tc)) begin
         exp_t got;
         exp_t e;
         got.q = o_q; got.busy = o_busy; got.done = o_done; got.tc = o_tc;
         n_chk++;
         if (sb.size() == 0) begin
            $display("FAIL unexpected_event: got q=%0d busy=%0b done=%0b tc=%0b expected no activity",
                     o_q, o_busy, o_done, o_tc);
         end else begin
            e = sb.pop_front();
            if (got === e) n_pass++;
            else $display("FAIL event: got q=%0d busy=%0b done=%0b tc=%0b expected q=%0d busy=%0b done=%0b tc=%0b",
                          got.q, got.busy, got.done, got.tc, e.q, e.busy, e.done, e.tc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_q",     {28'b0, o_q}, 32'd0);
      chk("rst_busy",  {31'b0, o_busy}, 32'd0);
      chk("rst_done",  {31'b0, o_done}, 32'd0);
      chk("rst_tc",    {31'b0, o_tc}, 32'd0);
      chk("rst_ready", {31'b0, o_cmd_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("ready_after_rst", {31'b0, o_cmd_ready}, 32'd1);

      // LOAD A
      push(4'd10, 0, 1, 0);
      send(2'b00, 4'hA, 0, 0);

      // LOAD 3, UP 5 wrap, back-to-back
      push(4'd3, 0, 1, 0);
      send(2'b00, 4'd3, 0, 0);
      push(4'd3, 1, 0, 0); push(4'd4, 1, 0, 0); push(4'd5, 1, 0, 0);
      push(4'd6, 1, 0, 0); push(4'd7, 1, 0, 0); push(4'd8, 0, 1, 0);
      send(2'b01, 4'd5, 0, 0);
      repeat (5) @(posedge clk);

      // LOAD 14, UP 4 wrap
      push(4'd14, 0, 1, 0);
      send(2'b00, 4'd14, 0, 0);
      push(4'd14, 1, 0, 0); push(4'd15, 1, 0, 0); push(4'd0, 1, 0, 1);
      push(4'd1, 1, 0, 0);  push(4'd2, 0, 1, 0);
      send(2'b01, 4'd4, 0, 0);
      repeat (4) @(posedge clk);

      // LOAD 14, UP 4 saturating
      push(4'd14, 0, 1, 0);
      send(2'b00, 4'd14, 0, 0);
      push(4'd14, 1, 0, 0); push(4'd15, 1, 0, 0); push(4'd15, 1, 0, 1);
      push(4'd15, 1, 0, 1); push(4'd15, 0, 1, 1);
      send(2'b01, 4'd4, 1, 0);
      repeat (4) @(posedge clk);

      // LOAD 1, DOWN 3 saturating, then CLEAR
      push(4'd1, 0, 1, 0);
      send(2'b00, 4'd1, 0, 0);
      push(4'd1, 1, 0, 0); push(4'd0, 1, 0, 0); push(4'd0, 1, 0, 1); push(4'd0, 0, 1, 1);
      send(2'b10, 4'd3, 1, 0);
      repeat (3) @(posedge clk);
      push(4'd0, 0, 1, 0);
      send(2'b11, 4'd7, 0, 0);
      push(4'd9, 0, 1, 0);
      send(2'b00, 4'd9, 0, 0);
      push(4'd0, 0, 1, 0);
      send(2'b11, 4'd5, 0, 0);

      // LOAD 1, DOWN 2 wrap: final step wraps, tc coincides with done
      push(4'd1, 0, 1, 0);
      send(2'b00, 4'd1, 0, 0);
      push(4'd1, 1, 0, 0); push(4'd0, 1, 0, 0); push(4'd15, 0, 1, 1);
      send(2'b10, 4'd2, 0, 0);
      repeat (2) @(posedge clk);

      // UP 10 from 0, abort after 3 steps
      push(4'd0, 0, 1, 0);
      send(2'b11, 4'd0, 0, 0);
      push(4'd0, 1, 0, 0); push(4'd1, 1, 0, 0); push(4'd2, 1, 0, 0); push(4'd3, 1, 0, 0);
      send(2'b01, 4'd10, 0, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      i_abort = 1'b1;
      @(posedge clk);
      #1 i_abort = 1'b0;
      chk("abort_q",     {28'b0, o_q}, 32'd3);
      chk("abort_busy",  {31'b0, o_busy}, 32'd0);
      chk("abort_done",  {31'b0, o_done}, 32'd0);
      chk("abort_ready", {31'b0, o_cmd_ready}, 32'd1);
      push(4'd5, 0, 1, 0);
      send(2'b00, 4'd5, 0, 0);

      // abort together with a command in IDLE: command wins
      push(4'd7, 0, 1, 0);
      send(2'b00, 4'd7, 0, 1);

      // reset asynchronously mid-RUN at q = 6
      push(4'd2, 0, 1, 0);
      send(2'b00, 4'd2, 0, 0);
      push(4'd2, 1, 0, 0); push(4'd3, 1, 0, 0); push(4'd4, 1, 0, 0);
      push(4'd5, 1, 0, 0); push(4'd6, 1, 0, 0);
      send(2'b01, 4'd10, 0, 0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_q",     {28'b0, o_q}, 32'd0);
      chk("arst_busy",  {31'b0, o_busy}, 32'd0);
      chk("arst_ready", {31'b0, o_cmd_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("arst_done", {31'b0, o_done}, 32'd0);

      // UP 0 after reset, then UP 0 at a nonzero value
      push(4'd0, 0, 1, 0);
      send(2'b01, 4'd0, 0, 0);
      push(4'd6, 0, 1, 0);
      send(2'b00, 4'd6, 0, 0);
      push(4'd6, 0, 1, 0);
      send(2'b10, 4'd0, 1, 0);

      repeat (4) @(posedge clk);
      @(negedge clk);
      #1 chk("scoreboard_drained", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
